// File: rtl/stdp_weight_reader.sv
// -----------------------------------------------------------------------------
// stdp_weight_reader
//
// Purpose:
//   Snapshots the packed synaptic weight vector from the STDP block and shifts
//   it off-chip MSB first as a framed serial stream. A frame starts on a
//   synchronized rising edge of the host request pin, or automatically (when
//   auto_en is set) once the STDP block has flagged an update since the last
//   snapshot. Each bit lasts CLK_DIV clk cycles: sclk is low for the first half
//   and high for the second half, so the receiver samples sdata on sclk rise.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   weight_in    packed weights ([15:12]=pre1 ... [3:0]=pre4 at WIDTH=16)
//   update_flag  STDP weight-update strobe, synchronous to clk
//   req_in       host read request from the pad, asynchronous to clk
//   auto_en      1 = start a frame automatically while dirty
//   busy         high whenever the block is not idle
//   frame        high for the whole data phase
//   sclk         serial clock
//   sdata        serial data, MSB first
//   done         one-cycle pulse after each frame
//   dirty        an update has occurred since the last snapshot
// -----------------------------------------------------------------------------
module stdp_weight_reader #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] weight_in,
    input  logic             update_flag,
    input  logic             req_in,
    input  logic             auto_en,
    output logic             busy,
    output logic             frame,
    output logic             sclk,
    output logic             sdata,
    output logic             done,
    output logic             dirty
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [DW-1:0] DIV_ZERO = DW'(0);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_ZERO = BW'(0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shift_reg;
    logic [BW-1:0]    r_bit_cnt;
    logic [DW-1:0]    r_div_cnt;
    logic             r_s1;
    logic             r_s2;
    logic             r_s3;

    logic [1:0]       w_state_nx;
    logic [WIDTH-1:0] w_shift_nx;
    logic [BW-1:0]    w_bit_nx;
    logic [DW-1:0]    w_div_nx;
    logic             w_req_edge;
    logic             w_start;
    logic             w_dirty_nx;

    // Rising edge of the synchronized request; history flop s3 holds last s2.
    assign w_req_edge = r_s2 & ~r_s3;

    // Starts are only honoured in IDLE, so requests arriving while busy are lost.
    assign w_start = (r_state == ST_IDLE) & (w_req_edge | (auto_en & dirty));

    // A new update always wins over the clear caused by a snapshot.
    assign w_dirty_nx = update_flag | (dirty & ~w_start);

    // Next-state, shift-register and counter logic for the frame sequencer.
    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift_reg;
        w_bit_nx   = r_bit_cnt;
        w_div_nx   = r_div_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nx = ST_SHIFT;
                    w_shift_nx = weight_in;
                    w_bit_nx   = BIT_LAST;
                    w_div_nx   = DIV_ZERO;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_nx = DIV_ZERO;
                    if (r_bit_cnt == BIT_ZERO) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_shift_nx = r_shift_reg << 1;
                        w_bit_nx   = r_bit_cnt - BIT_ONE;
                    end
                end else begin
                    w_div_nx = r_div_cnt + DIV_ONE;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Request synchronizer plus edge-history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= req_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Sequencer state, snapshot register, counters and dirty flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift_reg <= {WIDTH{1'b0}};
            r_bit_cnt   <= BIT_ZERO;
            r_div_cnt   <= DIV_ZERO;
            dirty       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_shift_reg <= w_shift_nx;
            r_bit_cnt   <= w_bit_nx;
            r_div_cnt   <= w_div_nx;
            dirty       <= w_dirty_nx;
        end
    end

    // Outputs decoded from the next state so they are registered yet stay
    // aligned with the state register; sdata/sclk only move at clk edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            frame <= 1'b0;
            sclk  <= 1'b0;
            sdata <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy  <= (w_state_nx != ST_IDLE);
            frame <= (w_state_nx == ST_SHIFT);
            sclk  <= (w_state_nx == ST_SHIFT) && (w_div_nx >= DIV_HALF);
            sdata <= (w_state_nx == ST_SHIFT) && w_shift_nx[WIDTH-1];
            done  <= (w_state_nx == ST_DONE);
        end
    end

endmodule

// File: tb/tb_stdp_weight_reader.sv
// -----------------------------------------------------------------------------
// tb_stdp_weight_reader
//
// Scoreboard bench for stdp_weight_reader (WIDTH=16, CLK_DIV=4). The stimulus
// pushes the weight word expected on the wire whenever it launches a frame; a
// monitor reassembles each frame from sdata at sclk rises and pops/compares.
// -----------------------------------------------------------------------------
module tb_stdp_weight_reader;

    logic        clk;
    logic        rst_n;
    logic [15:0] weight_in;
    logic        update_flag;
    logic        req_in;
    logic        auto_en;
    logic        busy;
    logic        frame;
    logic        sclk;
    logic        sdata;
    logic        done;
    logic        dirty;

    int          n_vec;
    int          n_err;
    int          n_frames;
    int          n_done;
    logic [15:0] exp_q[$];

    stdp_weight_reader #(.WIDTH(16), .CLK_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .weight_in   (weight_in),
        .update_flag (update_flag),
        .req_in      (req_in),
        .auto_en     (auto_en),
        .busy        (busy),
        .frame       (frame),
        .sclk        (sclk),
        .sdata       (sdata),
        .done        (done),
        .dirty       (dirty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [15:0] w);
        weight_in = w;
        exp_q.push_back(w);
        req_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            tick();
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (done) break;
            tick();
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    // Frame monitor: rebuild each frame, check length, sclk count and done.
    initial begin
        logic        prev_frame;
        logic        prev_sclk;
        logic        done_due;
        logic [15:0] acc;
        logic [15:0] exp_w;
        int          flen;
        int          rises;
        prev_frame = 1'b0;
        prev_sclk  = 1'b0;
        done_due   = 1'b0;
        acc        = 16'h0000;
        flen       = 0;
        rises      = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_frame = 1'b0;
                prev_sclk  = 1'b0;
                done_due   = 1'b0;
            end else begin
                if (done_due) begin
                    chk("post_done_idle", {29'd0, busy, done, frame}, 32'd0);
                    done_due = 1'b0;
                end
                if (frame) begin
                    if (!prev_frame) begin
                        n_frames++;
                        acc   = 16'h0000;
                        flen  = 0;
                        rises = 0;
                    end
                    flen++;
                    if (sclk && !prev_sclk) begin
                        acc = {acc[14:0], sdata};
                        rises++;
                    end
                end else if (prev_frame) begin
                    chk("done_after_frame", {31'd0, done}, 32'd1);
                    chk("busy_in_done", {31'd0, busy}, 32'd1);
                    chk("frame_len", flen, 32'd64);
                    chk("sclk_rises", rises, 32'd16);
                    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                    chk("frame_data", {16'd0, acc}, {16'd0, exp_w});
                    done_due = 1'b1;
                end
                if (done) n_done++;
                prev_frame = frame;
                prev_sclk  = sclk;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_frames;
        int base_done;
        n_vec       = 0;
        n_err       = 0;
        n_frames    = 0;
        n_done      = 0;
        rst_n       = 1'b0;
        weight_in   = 16'h0000;
        update_flag = 1'b0;
        req_in      = 1'b0;
        auto_en     = 1'b0;

        #2;
        chk("reset_outputs", {26'd0, busy, frame, sclk, sdata, done, dirty}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_after_reset", {31'd0, busy}, 32'd0);

        // Basic read with request latency.
        weight_in = 16'hA5C3;
        exp_q.push_back(16'hA5C3);
        req_in = 1'b1;
        tick();
        chk("lat_edge0", {31'd0, frame}, 32'd0);
        tick();
        chk("lat_edge1", {31'd0, frame}, 32'd0);
        tick();
        chk("lat_edge2_frame", {31'd0, frame}, 32'd1);
        chk("lat_edge2_busy", {31'd0, busy}, 32'd1);
        chk("first_sdata", {31'd0, sdata}, 32'd1);
        req_in = 1'b0;
        wait_idle("basic_idle");
        repeat (5) tick();

        // Auto mode: one-cycle update strobe.
        auto_en     = 1'b1;
        weight_in   = 16'h1234;
        exp_q.push_back(16'h1234);
        update_flag = 1'b1;
        tick();
        update_flag = 1'b0;
        chk("auto_dirty_set", {31'd0, dirty}, 32'd1);
        chk("auto_no_frame_yet", {31'd0, frame}, 32'd0);
        tick();
        chk("auto_frame", {31'd0, frame}, 32'd1);
        chk("auto_dirty_clr", {31'd0, dirty}, 32'd0);
        wait_idle("auto_idle");
        repeat (5) tick();
        chk("auto_dirty_after", {31'd0, dirty}, 32'd0);
        auto_en = 1'b0;

        // Dropped request and snapshot hold.
        base_frames = n_frames;
        start_req(16'h5A0F);
        repeat (20) tick();
        weight_in = 16'hFFFF;
        req_in    = 1'b1;
        repeat (3) tick();
        req_in = 1'b0;
        wait_idle("drop_idle");
        repeat (10) tick();
        chk("drop_one_frame", n_frames - base_frames, 32'd1);
        chk("drop_stays_idle", {31'd0, busy}, 32'd0);

        // Update/clear collision in auto mode.
        base_frames = n_frames;
        auto_en     = 1'b1;
        weight_in   = 16'h0F0F;
        exp_q.push_back(16'h0F0F);
        update_flag = 1'b1;
        tick();
        chk("coll_dirty_set", {31'd0, dirty}, 32'd1);
        tick();
        update_flag = 1'b0;
        chk("coll_frame", {31'd0, frame}, 32'd1);
        chk("coll_dirty_kept", {31'd0, dirty}, 32'd1);
        weight_in = 16'hC3A5;
        exp_q.push_back(16'hC3A5);
        repeat (30) tick();
        update_flag = 1'b1;
        tick();
        update_flag = 1'b0;
        chk("coll_dirty_mid", {31'd0, dirty}, 32'd1);
        wait_done("coll_done");
        tick();
        chk("coll_gap_idle", {30'd0, busy, frame}, 32'd0);
        tick();
        chk("coll_restart", {31'd0, frame}, 32'd1);
        chk("coll_dirty_cleared", {31'd0, dirty}, 32'd0);
        wait_idle("coll_idle");
        auto_en = 1'b0;
        repeat (10) tick();
        chk("coll_two_frames", n_frames - base_frames, 32'd2);

        // Reset during bit 5 aborts the frame without done.
        base_frames = n_frames;
        start_req(16'hBEEF);
        repeat (21) tick();
        base_done = n_done;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {26'd0, busy, frame, sclk, sdata, done, dirty}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) tick();
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        chk("midrst_no_done", n_done - base_done, 32'd0);
        chk("midrst_frames", n_frames - base_frames, 32'd1);

        // Request held high across reset release gives exactly one frame.
        base_frames = n_frames;
        weight_in   = 16'h8001;
        exp_q.push_back(16'h8001);
        req_in = 1'b1;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (150) tick();
        req_in = 1'b0;
        wait_idle("held_idle");
        repeat (10) tick();
        chk("held_one_frame", n_frames - base_frames, 32'd1);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
